// File: rtl/mem_result_streamer_pkg.sv
// Shared sizing, FSM encoding and helpers for the result RAM streamer.
package mem_result_streamer_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned CSUM_W = 14;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Limit a requested word count to the RAM depth.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : c;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO; the head entry is a register so the output is glitch-free
// and holds while the consumer stalls. Writers must not push while full.
module stream_fifo2 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              push_c, pop_c;

    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = head_q;
    assign count_o     = cnt_q;
    assign push_c      = in_valid_i && (cnt_q != 2'd2);
    assign pop_c       = out_valid_o && out_ready_i;

    // Next contents: pops shift tail into head, pushes fill the first free slot.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_c, pop_c})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = in_data_i;
                else               tail_d = in_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            // Push with pop only happens at one entry, so the new word becomes head.
            2'b11: head_d = in_data_i;
            default: ;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_result_streamer.sv
// Streams the result RAM from address 0 onto a valid/ready port, hiding the
// 1-cycle RAM read latency behind a 2-entry FIFO and summing delivered beats.
module mem_result_streamer
    import mem_result_streamer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic [CSUM_W-1:0] checksum
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic [CSUM_W-1:0] csum_q, csum_d;

    logic [1:0]        fifo_cnt;
    logic              pop_c;
    logic              issue_c;
    logic              last_c;
    logic [2:0]        credit_c;

    stream_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inflight_q),
        .in_data_i   (mem_dout),
        .out_valid_o (m_valid),
        .out_data_o  (m_data),
        .out_ready_i (m_ready),
        .count_o     (fifo_cnt)
    );

    // Words held after this cycle's pop plus the word returning from the RAM.
    assign pop_c    = m_valid && m_ready;
    assign credit_c = {1'b0, fifo_cnt} - 3'(pop_c) + 3'(inflight_q);
    assign last_c   = (CNT_W'(addr_q) + CNT_W'(1)) == len_q;

    assign mem_en   = issue_c;
    assign mem_addr = addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign checksum = csum_q;

    // Run sequencing, read issue and checksum accumulation.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        csum_d     = csum_q;
        issue_c    = 1'b0;
        if (pop_c) csum_d = csum_q + CSUM_W'(m_data);
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = clamp_count(count);
                    addr_d  = '0;
                    csum_d  = '0;
                    state_d = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (credit_c < 3'd2) begin
                    issue_c = 1'b1;
                    // Hold the address on the final read so it never wraps.
                    if (last_c) state_d = DRAIN;
                    else        addr_d  = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if ((credit_c == 3'd0) && !inflight_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        inflight_d = issue_c;
    end

    // Control state registers; reset discards any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            csum_q     <= csum_d;
        end
    end

endmodule

// File: tb/tb_mem_result_streamer.sv
// Scoreboard bench for mem_result_streamer: tests push expected beats, a
// negedge monitor pops and compares every transferred beat.
module tb_mem_result_streamer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  count;
    logic        mem_en;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic [13:0] checksum;

    int n_tests;
    int n_fail;

    logic [7:0] ram [64];
    logic [7:0] exp_q [$];

    int         beat_cnt;
    int         done_cnt;
    int         en_cnt;
    int         valid_cnt;
    logic [5:0] last_addr;
    logic       prev_stall;
    logic [7:0] prev_data;

    mem_result_streamer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count    (count),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares each beat against the scoreboard and tracks activity.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", 32'(m_valid), 32'd1);
                check("stall_data_hold", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_queue_empty", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                beat_cnt <= beat_cnt + 1;
            end
            if (done)    done_cnt  <= done_cnt + 1;
            if (m_valid) valid_cnt <= valid_cnt + 1;
            if (mem_en) begin
                en_cnt    <= en_cnt + 1;
                last_addr <= mem_addr;
            end
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
        end
    end

    task automatic fill_ramp(input logic [7:0] base);
        for (int i = 0; i < 64; i++) ram[i] = base + 8'(i);
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ram[i]);
    endtask

    // Pulse start and wait for done; edges counts clock edges after the accepting edge.
    task automatic run(input int cnt, input bit toggle, input bit inject,
                       input int budget, output int edges);
        start = 1'b1;
        count = 7'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < budget) begin
            if (toggle) m_ready = ((edges % 4) == 0) || ((edges % 4) == 3);
            if (inject && edges == 3) begin
                start = 1'b1;
                count = 7'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        if (!done) check("done_timeout", 32'(edges), 32'(budget + 1));
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    int edges;
    int b0, d0, e0, v0;

    task automatic snap();
        b0 = beat_cnt;
        d0 = done_cnt;
        e0 = en_cnt;
        v0 = valid_cnt;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        beat_cnt   = 0;
        done_cnt   = 0;
        en_cnt     = 0;
        valid_cnt  = 0;
        last_addr  = '0;
        prev_stall = 1'b0;
        prev_data  = '0;
        mem_dout   = '0;
        rst        = 1'b1;
        start      = 1'b0;
        count      = '0;
        m_ready    = 1'b1;
        fill_ramp(8'd0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: four-word ramp, ready high.
        fill_ramp(8'd0);
        push_exp(4);
        snap();
        start = 1'b1;
        count = 7'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("t1_busy_after_accept", 32'(busy), 32'd1);
        check("t1_first_read_en", 32'(mem_en), 32'd1);
        check("t1_first_read_addr", 32'(mem_addr), 32'd0);
        edges = 0;
        while (!m_valid && edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        check("t1_first_valid_latency", 32'(edges), 32'd2);
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check("t1_done_edge", 32'(edges), 32'd6);
        settle();
        check("t1_beats", 32'(beat_cnt - b0), 32'd4);
        check("t1_checksum", 32'(checksum), 32'd6);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: full RAM of FF.
        for (int i = 0; i < 64; i++) ram[i] = 8'hFF;
        push_exp(64);
        snap();
        run(64, 1'b0, 1'b0, 200, edges);
        check("t2_done_edge", 32'(edges), 32'd66);
        settle();
        check("t2_beats", 32'(beat_cnt - b0), 32'd64);
        check("t2_reads", 32'(en_cnt - e0), 32'd64);
        check("t2_last_addr", 32'(last_addr), 32'd63);
        check("t2_checksum", 32'(checksum), 32'd16320);
        check("t2_busy_low", 32'(busy), 32'd0);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 3: ramp of eight with ready toggling 1,0,0,1.
        fill_ramp(8'd0);
        push_exp(8);
        snap();
        run(8, 1'b1, 1'b0, 200, edges);
        settle();
        check("t3_beats", 32'(beat_cnt - b0), 32'd8);
        check("t3_checksum", 32'(checksum), 32'd28);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 4a: empty run.
        snap();
        run(0, 1'b0, 1'b0, 20, edges);
        check("t4_zero_done_edge", 32'(edges), 32'd0);
        settle();
        check("t4_zero_reads", 32'(en_cnt - e0), 32'd0);
        check("t4_zero_valid", 32'(valid_cnt - v0), 32'd0);
        check("t4_zero_checksum", 32'(checksum), 32'd0);
        check("t4_zero_done_pulses", 32'(done_cnt - d0), 32'd1);

        // 4b: oversized request clamps to the RAM depth.
        push_exp(64);
        snap();
        run(100, 1'b0, 1'b0, 200, edges);
        check("t4_clamp_done_edge", 32'(edges), 32'd66);
        settle();
        check("t4_clamp_beats", 32'(beat_cnt - b0), 32'd64);
        check("t4_clamp_checksum", 32'(checksum), 32'd2016);
        check("t4_clamp_last_addr", 32'(last_addr), 32'd63);

        // 5: second start mid-run is ignored.
        push_exp(8);
        snap();
        run(8, 1'b0, 1'b1, 200, edges);
        settle();
        check("t5_beats", 32'(beat_cnt - b0), 32'd8);
        check("t5_checksum", 32'(checksum), 32'd28);
        check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset after the third beat with a read in flight, then restart.
        fill_ramp(8'hA0);
        push_exp(8);
        snap();
        start = 1'b1;
        count = 7'd8;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while ((beat_cnt - b0) < 3 && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check("t6_three_beats_before_rst", 32'(beat_cnt - b0), 32'd3);
        rst = 1'b1;
        #2;
        check("t6_rst_mem_en", 32'(mem_en), 32'd0);
        check("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("t6_rst_m_valid", 32'(m_valid), 32'd0);
        check("t6_rst_m_data", 32'(m_data), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_checksum", 32'(checksum), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_exp(2);
        snap();
        run(2, 1'b0, 1'b0, 50, edges);
        settle();
        check("t6_beats", 32'(beat_cnt - b0), 32'd2);
        check("t6_checksum", 32'(checksum), 32'd321);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
